// File: rtl/multi_port_banked_sram_pkg.sv
// Shared constants, types and helpers for the banked scratchpad SRAM.
package gpgpu_sram_pkg;

  localparam int unsigned BYTE_PER_WORD = 4;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  be_t;

  // Index width that never collapses to zero, so single-entry selects stay legal.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_port_banked_sram_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner.
module rr_arbiter
  import gpgpu_sram_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = sel_width(N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_i,
  input  logic             advance_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] winner_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;

  always_comb begin
    int unsigned      idx;
    logic [IDX_W-1:0] idx_w;
    gnt_o    = '0;
    winner_o = ptr_q;
    found    = 1'b0;
    idx      = 0;
    idx_w    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = i + 32'(ptr_q);
      if (idx >= N) begin
        idx = idx - N;
      end
      idx_w = IDX_W'(idx);
      if (!found && req_i[idx_w]) begin
        found        = 1'b1;
        gnt_o[idx_w] = 1'b1;
        winner_o     = idx_w;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = (winner_o == IDX_W'(N - 1)) ? '0 : winner_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/multi_port_banked_sram.sv
// N-port word-interleaved banked SRAM with per-bank round-robin arbitration
// and a registered one-cycle response channel per port.
module multi_port_banked_sram
  import gpgpu_sram_pkg::*;
#(
  parameter int unsigned MEM_SIZE_BYTE = 32768,
  parameter int unsigned N_PORTS       = 4,
  parameter int unsigned N_BANKS       = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [N_PORTS-1:0]                    req_i,
  output logic [N_PORTS-1:0]                    gnt_o,
  input  logic [N_PORTS-1:0][31:0]              addr_i,
  input  logic [N_PORTS-1:0]                    we_i,
  input  logic [N_PORTS-1:0][BYTE_PER_WORD-1:0] be_i,
  input  logic [N_PORTS-1:0][31:0]              wdata_i,
  output logic [N_PORTS-1:0]                    rvalid_o,
  output logic [N_PORTS-1:0][31:0]              rdata_o
);

  localparam int unsigned N_WORDS    = MEM_SIZE_BYTE / BYTE_PER_WORD;
  localparam int unsigned N_ROWS     = N_WORDS / N_BANKS;
  localparam int unsigned WIDX_W     = $clog2(N_WORDS);
  localparam int unsigned BANK_SHIFT = $clog2(N_BANKS);
  localparam int unsigned BANK_W     = sel_width(N_BANKS);
  localparam int unsigned ROW_W      = sel_width(N_ROWS);
  localparam int unsigned PORT_W     = sel_width(N_PORTS);

  logic [N_PORTS-1:0][WIDX_W-1:0] word_idx;
  logic [N_PORTS-1:0][BANK_W-1:0] port_bank;
  logic [N_PORTS-1:0][ROW_W-1:0]  port_row;

  logic [N_BANKS-1:0][N_PORTS-1:0] bank_req;
  logic [N_BANKS-1:0][N_PORTS-1:0] bank_gnt;
  logic [N_BANKS-1:0][PORT_W-1:0]  bank_winner;
  logic [N_BANKS-1:0]              bank_we;
  be_t                             bank_be    [N_BANKS];
  word_t                           bank_wdata [N_BANKS];
  logic [ROW_W-1:0]                bank_row   [N_BANKS];

  word_t mem [N_BANKS][N_ROWS];

  logic [N_PORTS-1:0]       rvalid_q, rvalid_d;
  logic [N_PORTS-1:0][31:0] rdata_q, rdata_d;

  // Upper address bits and the byte offset are intentionally ignored (wrap).
  logic addr_unused;
  assign addr_unused = ^addr_i;

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      word_idx[p]  = addr_i[p][WIDX_W+1:2];
      port_bank[p] = BANK_W'(word_idx[p] & WIDX_W'(N_BANKS - 1));
      port_row[p]  = ROW_W'(word_idx[p] >> BANK_SHIFT);
    end
  end

  always_comb begin
    for (int b = 0; b < N_BANKS; b++) begin
      for (int p = 0; p < N_PORTS; p++) begin
        bank_req[b][p] = rst_ni && req_i[p] && (port_bank[p] == BANK_W'(b));
      end
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    rr_arbiter #(
      .N (N_PORTS)
    ) u_arb (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (bank_req[b]),
      .advance_i (|bank_req[b]),
      .gnt_o     (bank_gnt[b]),
      .winner_o  (bank_winner[b])
    );
  end

  always_comb begin
    gnt_o = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      gnt_o = gnt_o | bank_gnt[b];
    end
  end

  // Steer the winning port's write onto its bank.
  always_comb begin
    for (int b = 0; b < N_BANKS; b++) begin
      bank_we[b]    = (|bank_gnt[b]) && we_i[bank_winner[b]];
      bank_be[b]    = be_i[bank_winner[b]];
      bank_wdata[b] = wdata_i[bank_winner[b]];
      bank_row[b]   = port_row[bank_winner[b]];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < N_BANKS; b++) begin
      if (bank_we[b]) begin
        for (int k = 0; k < BYTE_PER_WORD; k++) begin
          if (bank_be[b][k]) begin
            mem[b][bank_row[b]][8*k +: 8] <= bank_wdata[b][8*k +: 8];
          end
        end
      end
    end
  end

  // Ungranted ports keep their last read data; writes answer with zero.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      rvalid_d[p] = gnt_o[p];
      rdata_d[p]  = rdata_q[p];
      if (gnt_o[p]) begin
        rdata_d[p] = we_i[p] ? '0 : mem[port_bank[p]][port_row[p]];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_multi_port_banked_sram.sv
// Self-checking bench: directed scenarios plus random traffic, checked every
// cycle against a word-array model with rule-based round-robin arbitration.
module tb_multi_port_banked_sram;

  localparam int unsigned MEM_SIZE_BYTE = 32768;
  localparam int unsigned N_PORTS       = 4;
  localparam int unsigned N_BANKS       = 4;
  localparam int unsigned N_WORDS       = MEM_SIZE_BYTE / 4;

  logic                       clk_i  = 1'b0;
  logic                       rst_ni = 1'b0;
  logic [N_PORTS-1:0]         req_i;
  logic [N_PORTS-1:0]         gnt_o;
  logic [N_PORTS-1:0][31:0]   addr_i;
  logic [N_PORTS-1:0]         we_i;
  logic [N_PORTS-1:0][3:0]    be_i;
  logic [N_PORTS-1:0][31:0]   wdata_i;
  logic [N_PORTS-1:0]         rvalid_o;
  logic [N_PORTS-1:0][31:0]   rdata_o;

  multi_port_banked_sram #(
    .MEM_SIZE_BYTE (MEM_SIZE_BYTE),
    .N_PORTS       (N_PORTS),
    .N_BANKS       (N_BANKS)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .be_i     (be_i),
    .wdata_i  (wdata_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [31:0]        model_mem [N_WORDS];
  bit                 written   [N_WORDS];
  int                 ptr       [N_BANKS];
  logic [N_PORTS-1:0] exp_rvalid = '0;
  logic [31:0]        exp_rdata [N_PORTS];
  bit                 exp_known [N_PORTS];
  logic [N_PORTS-1:0] last_gnt = '0;

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % N_WORDS);
  endfunction

  function automatic logic [31:0] init_val(input int w);
    return (w == 0) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(w) * 32'h0101;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs with the model, then advance the model by one clock edge.
  task automatic checkOutput();
    logic [N_PORTS-1:0] g;
    int                 nptr [N_BANKS];
    int                 p;
    int                 w;
    bit                 done;
    g = '0;
    for (int b = 0; b < N_BANKS; b++) nptr[b] = ptr[b];
    if (rst_ni) begin
      for (int b = 0; b < N_BANKS; b++) begin
        done = 0;
        for (int i = 0; i < N_PORTS; i++) begin
          p = (ptr[b] + i) % N_PORTS;
          if (!done && req_i[p] && (word_of(addr_i[p]) % N_BANKS) == b) begin
            g[p]    = 1'b1;
            nptr[b] = (p + 1) % N_PORTS;
            done    = 1;
          end
        end
      end
    end
    check("gnt_o", gnt_o, g);
    check("rvalid_o", rvalid_o, exp_rvalid);
    for (int q = 0; q < N_PORTS; q++) begin
      if (exp_known[q]) check($sformatf("rdata_o[%0d]", q), rdata_o[q], exp_rdata[q]);
    end
    if (!rst_ni) begin
      exp_rvalid = '0;
      for (int q = 0; q < N_PORTS; q++) begin
        exp_rdata[q] = '0;
        exp_known[q] = 1;
      end
      for (int b = 0; b < N_BANKS; b++) ptr[b] = 0;
    end else begin
      for (int q = 0; q < N_PORTS; q++) begin
        if (g[q]) begin
          w = word_of(addr_i[q]);
          exp_rdata[q] = we_i[q] ? 32'h0 : model_mem[w];
          exp_known[q] = we_i[q] || written[w];
        end
      end
      for (int q = 0; q < N_PORTS; q++) begin
        if (g[q] && we_i[q]) begin
          w = word_of(addr_i[q]);
          for (int k = 0; k < 4; k++) begin
            if (be_i[q][k]) model_mem[w][8*k +: 8] = wdata_i[q][8*k +: 8];
          end
          if (be_i[q] == 4'hF) written[w] = 1;
        end
      end
      exp_rvalid = g;
      for (int b = 0; b < N_BANKS; b++) ptr[b] = nptr[b];
    end
    last_gnt = g;
  endtask

  task automatic step();
    @(negedge clk_i);
    checkOutput();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input int p, input logic req, input logic we,
                               input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata);
    req_i[p]   = req;
    we_i[p]    = we;
    addr_i[p]  = addr;
    be_i[p]    = be;
    wdata_i[p] = wdata;
  endtask

  task automatic clearAll();
    for (int p = 0; p < N_PORTS; p++) applyStimulus(p, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    int w;
    logic [31:0] a;
    clearAll();
    for (int q = 0; q < N_PORTS; q++) begin
      exp_rdata[q] = '0;
      exp_known[q] = 1;
    end
    for (int b = 0; b < N_BANKS; b++) ptr[b] = 0;
    @(posedge clk_i);
    #1;
    step();
    rst_ni = 1'b1;

    // Preload words 0..63, one word per bank per cycle.
    for (int k = 0; k < 16; k++) begin
      for (int p = 0; p < N_PORTS; p++) begin
        w = 4 * k + p;
        applyStimulus(p, 1'b1, 1'b1, 32'(w) << 2, 4'hF, init_val(w));
      end
      step();
    end

    // Reset with every port trying to write: nothing granted, nothing stored.
    for (int p = 0; p < N_PORTS; p++) applyStimulus(p, 1'b1, 1'b1, 32'(p * 4), 4'hF, 32'hBAD0_0000 | 32'(p));
    rst_ni = 1'b0;
    repeat (3) step();
    check("rst_gnt", gnt_o, 32'h0);
    check("rst_rvalid", rvalid_o, 32'h0);
    for (int p = 0; p < N_PORTS; p++) check($sformatf("rst_rdata%0d", p), rdata_o[p], 32'h0);

    // Four ports, four different banks, all in one cycle.
    rst_ni = 1'b1;
    for (int p = 0; p < N_PORTS; p++) applyStimulus(p, 1'b1, 1'b0, 32'(p * 4), 4'h0, 32'h0);
    #1;
    check("par_gnt", gnt_o, 32'hF);
    step();
    clearAll();
    check("par_rvalid", rvalid_o, 32'hF);
    check("par_rdata0", rdata_o[0], 32'hDEADBEEF);
    check("par_rdata1", rdata_o[1], 32'h1000_0101);
    check("par_rdata2", rdata_o[2], 32'h1000_0202);
    check("par_rdata3", rdata_o[3], 32'h1000_0303);

    // Full contention on bank 0 from a fresh reset.
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    for (int p = 0; p < N_PORTS; p++) applyStimulus(p, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("fair_gnt%0d", k), gnt_o, 32'h1 << (k % 4));
      step();
      check($sformatf("fair_rvalid%0d", k), rvalid_o, 32'h1 << (k % 4));
    end
    clearAll();
    step();

    // Byte-enable merge at 0x20.
    applyStimulus(0, 1'b1, 1'b1, 32'h20, 4'hF, 32'h11223344);
    step();
    applyStimulus(0, 1'b1, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    step();
    check("be_wr_rvalid", rvalid_o[0], 32'h1);
    check("be_wr_rdata", rdata_o[0], 32'h0);
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    step();
    check("be_rd_rdata", rdata_o[0], 32'h11BB33DD);
    clearAll();

    // Address wrap and read-after-write on the next cycle.
    applyStimulus(1, 1'b1, 1'b1, 32'h0000_8004, 4'hF, 32'h12345678);
    step();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyStimulus(2, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
    step();
    check("raw_rvalid", rvalid_o[2], 32'h1);
    check("raw_rdata", rdata_o[2], 32'h12345678);
    clearAll();

    // Reset right after a granted read drops its response and rewinds the pointer.
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    step();
    clearAll();
    rst_ni = 1'b0;
    step();
    check("midrst_rvalid", rvalid_o, 32'h0);
    rst_ni = 1'b1;
    for (int p = 0; p < N_PORTS; p++) applyStimulus(p, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    #1;
    check("midrst_gnt", gnt_o, 32'h1);
    step();
    clearAll();
    step();

    // Random traffic on a small window with aliased upper bits; losers hold.
    for (int c = 0; c < 800; c++) begin
      rst_ni = ($urandom_range(0, 99) != 0);
      for (int p = 0; p < N_PORTS; p++) begin
        if (!(req_i[p] && !last_gnt[p])) begin
          if ($urandom_range(0, 3) != 0) begin
            w = int'($urandom_range(0, 63));
            a = ($urandom & 32'hFFFF_8003) | (32'(w) << 2);
            applyStimulus(p, 1'b1, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
          end else begin
            applyStimulus(p, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
          end
        end
      end
      step();
    end
    rst_ni = 1'b1;
    clearAll();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
